// File: rtl/qcl_counter_pkg.sv
// Shared types for the QCL counter family.
package qcl_counter_pkg;

    // Counter FSM states; IDLE accepts a new period, RUN counts it down.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cnt_state_e;

endpackage : qcl_counter_pkg

// File: rtl/qcl_counter_dynamic_load_down_if.sv
// Load/count/status bundle of the loadable down-counter.
// The master side hands over a period and controls counting;
// the slave side is the counter itself.
interface qcl_counter_dynamic_load_down_if #(
    parameter int width_p = 16
);
    logic               load_v_i;
    logic [width_p-1:0] load_limit_i;
    logic               load_ready_o;
    logic               en_i;
    logic               reload_en_i;
    logic               abort_i;
    logic [width_p-1:0] count_o;
    logic               expire_o;
    logic               busy_o;

    modport master (
        output load_v_i,
        output load_limit_i,
        output en_i,
        output reload_en_i,
        output abort_i,
        input  load_ready_o,
        input  count_o,
        input  expire_o,
        input  busy_o
    );

    modport slave (
        input  load_v_i,
        input  load_limit_i,
        input  en_i,
        input  reload_en_i,
        input  abort_i,
        output load_ready_o,
        output count_o,
        output expire_o,
        output busy_o
    );
endinterface : qcl_counter_dynamic_load_down_if

// File: rtl/qcl_counter_dynamic_load_down.sv
// Loadable down-counter/timer. A period accepted on the load port is
// counted down over enabled cycles; expire_o strobes in the final
// enabled cycle. Optional zero-gap auto-reload and an abort that
// cancels a running count. count_o shows remaining count minus one.
module qcl_counter_dynamic_load_down
    import qcl_counter_pkg::*;
#(
    parameter int width_p = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    qcl_counter_dynamic_load_down_if.slave bus
);

    localparam logic [width_p-1:0] ONE  = width_p'(1);
    localparam logic [width_p-1:0] ZERO = '0;

    cnt_state_e         state_r, state_n;
    logic [width_p-1:0] count_r, count_n;
    logic [width_p-1:0] limit_r, limit_n;

    logic count_zero;
    logic in_run;
    logic accept;
    logic expire;

    assign in_run     = (state_r == RUN);
    assign count_zero = (count_r == ZERO);

    // Ready only in IDLE and never while reset is held.
    assign bus.load_ready_o = reset_n_i & ~in_run;
    assign accept           = bus.load_v_i & bus.load_ready_o;

    // Final enabled cycle of a run; abort wins over expire.
    assign expire       = in_run & bus.en_i & count_zero & ~bus.abort_i;
    assign bus.expire_o = expire;

    assign bus.count_o = count_r;
    assign bus.busy_o  = in_run;

    // Next-state and datapath: abort > expire > decrement > hold.
    always_comb begin
        state_n = state_r;
        count_n = count_r;
        limit_n = limit_r;
        unique case (state_r)
            IDLE: begin
                // A zero-length period is consumed without starting a run.
                if (accept && (bus.load_limit_i != ZERO)) begin
                    limit_n = bus.load_limit_i;
                    count_n = bus.load_limit_i - ONE;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (bus.abort_i) begin
                    state_n = IDLE;
                    count_n = ZERO;
                end else if (expire) begin
                    if (bus.reload_en_i) begin
                        // limit_r is never zero in RUN, so this cannot wrap.
                        count_n = limit_r - ONE;
                    end else begin
                        state_n = IDLE;
                        count_n = ZERO;
                    end
                end else if (bus.en_i) begin
                    count_n = count_r - ONE;
                end
            end
            default: begin
                state_n = IDLE;
                count_n = ZERO;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            count_r <= ZERO;
            limit_r <= ZERO;
        end else begin
            state_r <= state_n;
            count_r <= count_n;
            limit_r <= limit_n;
        end
    end

endmodule : qcl_counter_dynamic_load_down

// File: tb/tb_qcl_counter_dynamic_load_down.sv
// Directed bench for qcl_counter_dynamic_load_down (width_p = 4).
module tb_qcl_counter_dynamic_load_down;

    localparam int W = 4;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    qcl_counter_dynamic_load_down_if #(.width_p(W)) bus ();

    qcl_counter_dynamic_load_down #(.width_p(W)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Check this cycle's outputs mid-cycle, then advance to just after the next edge.
    task automatic cyc(input string tag, input int b, input int c, input int e, input int r);
        @(negedge clk);
        chk({tag, ".busy"},   32'(bus.busy_o),       b);
        chk({tag, ".count"},  32'(bus.count_o),      c);
        chk({tag, ".expire"}, 32'(bus.expire_o),     e);
        chk({tag, ".ready"},  32'(bus.load_ready_o), r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus.load_v_i     = 1'b1;
        bus.load_limit_i = 4'd5;
        bus.en_i         = 1'b1;
        bus.reload_en_i  = 1'b0;
        bus.abort_i      = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with a pending load: nothing accepted.
        for (int i = 0; i < 3; i++) cyc("rst", 0, 0, 0, 0);

        // Basic run of 3.
        reset_n = 1'b1;
        bus.load_limit_i = 4'd3;
        cyc("b_acc", 0, 0, 0, 1);
        bus.load_v_i = 1'b0;
        cyc("b_c2", 1, 2, 0, 0);
        cyc("b_c1", 1, 1, 0, 0);
        cyc("b_c0", 1, 0, 1, 0);
        cyc("b_idle", 0, 0, 0, 1);

        // Enable gating: load 4, en 1,0,0,1,1,1.
        bus.load_v_i = 1'b1;
        bus.load_limit_i = 4'd4;
        cyc("g_acc", 0, 0, 0, 1);
        bus.load_v_i = 1'b0;
        bus.en_i = 1'b1; cyc("g1", 1, 3, 0, 0);
        bus.en_i = 1'b0; cyc("g2", 1, 2, 0, 0);
        bus.en_i = 1'b0; cyc("g3", 1, 2, 0, 0);
        bus.en_i = 1'b1; cyc("g4", 1, 2, 0, 0);
        cyc("g5", 1, 1, 0, 0);
        cyc("g6", 1, 0, 1, 0);
        cyc("g_idle", 0, 0, 0, 1);

        // Auto-reload period 2 with a load held during RUN (must be ignored).
        bus.reload_en_i = 1'b1;
        bus.load_v_i = 1'b1;
        bus.load_limit_i = 4'd2;
        cyc("r_acc", 0, 0, 0, 1);
        bus.load_limit_i = 4'd7;
        cyc("r1", 1, 1, 0, 0);
        cyc("r2", 1, 0, 1, 0);
        cyc("r3", 1, 1, 0, 0);
        cyc("r4", 1, 0, 1, 0);
        cyc("r5", 1, 1, 0, 0);
        bus.reload_en_i = 1'b0;
        cyc("r6", 1, 0, 1, 0);
        // Load 1 with reload: expire every cycle.
        bus.reload_en_i = 1'b1;
        bus.load_limit_i = 4'd1;
        cyc("r1_acc", 0, 0, 0, 1);
        bus.load_v_i = 1'b0;
        for (int i = 0; i < 3; i++) cyc("r1_run", 1, 0, 1, 0);
        bus.reload_en_i = 1'b0;
        cyc("r1_last", 1, 0, 1, 0);
        cyc("r1_idle", 0, 0, 0, 1);

        // Abort coinciding with the final count.
        bus.load_v_i = 1'b1;
        bus.load_limit_i = 4'd2;
        cyc("a_acc", 0, 0, 0, 1);
        bus.load_v_i = 1'b0;
        cyc("a1", 1, 1, 0, 0);
        bus.abort_i = 1'b1;
        cyc("a0", 1, 0, 0, 0);
        bus.abort_i = 1'b0;
        cyc("a_idle", 0, 0, 0, 1);

        // Zero-length load: consumed, no run.
        bus.load_v_i = 1'b1;
        bus.load_limit_i = 4'd0;
        cyc("z_acc", 0, 0, 0, 1);
        bus.load_v_i = 1'b0;
        cyc("z1", 0, 0, 0, 1);
        cyc("z2", 0, 0, 0, 1);

        // Maximum period 15.
        bus.load_v_i = 1'b1;
        bus.load_limit_i = 4'd15;
        cyc("m_acc", 0, 0, 0, 1);
        bus.load_v_i = 1'b0;
        for (int i = 0; i < 15; i++) cyc("m_run", 1, 14 - i, (i == 14) ? 1 : 0, 0);
        cyc("m_idle", 0, 0, 0, 1);

        // Reset mid-run at count 5.
        bus.load_v_i = 1'b1;
        bus.load_limit_i = 4'd10;
        cyc("x_acc", 0, 0, 0, 1);
        bus.load_v_i = 1'b0;
        for (int i = 0; i < 4; i++) cyc("x_run", 1, 9 - i, 0, 0);
        reset_n = 1'b0;
        cyc("x_rst", 1, 5, 0, 0);
        reset_n = 1'b1;
        cyc("x_after", 0, 0, 0, 1);
        cyc("x_after2", 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_qcl_counter_dynamic_load_down
